// File: rtl/darkuart_pkg.sv
// Shared constants, FSM state encoding and baud divisor helper for darkuart_bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package darkuart_pkg;

    // Frame command bytes and reply bytes exchanged with the host
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_BE,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_CAP,
        ST_SEND_ACK,
        ST_SEND_NAK,
        ST_SEND_DATA
    } state_e;

    // Clocks per serial bit, truncated; callers must keep the result >= 4
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/darkuart_bridge_rx.sv
// 8N1 serial receiver: 2-flop sync, falling-edge start detect, mid-bit sampling.
// Latency: byte_vld_o/ferr_o pulse one cycle after the stop bit is sampled at mid-bit.
// Backpressure: none; consumers must take byte_dat_o on the byte_vld_o pulse.
// Ports: clk_i, rst_i (async active-high), rxd_i (raw serial in),
//        byte_vld_o/byte_dat_o (received byte), ferr_o (stop bit sampled low).
module darkuart_bridge_rx #(
    parameter int unsigned DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_dat_o,
    output logic       ferr_o
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     state_q;
    logic          rxd_meta_q;
    logic          rxd_sync_q;
    logic          rxd_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          vld_q;
    logic          ferr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            vld_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            vld_q      <= 1'b0;
            ferr_q     <= 1'b0;
            case (state_q)
                // Edge (not level) detect so a line held low after a framing
                // error does not immediately re-trigger a bogus start bit.
                RX_IDLE: begin
                    if (rxd_prev_q && !rxd_sync_q) begin
                        cnt_q   <= HALF_M1;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rxd_sync_q) begin
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q   <= FULL_M1;
                        bit_q   <= '0;
                        state_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rxd_sync_q, shift_q[7:1]};
                        cnt_q   <= FULL_M1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        vld_q   <= rxd_sync_q;
                        ferr_q  <= !rxd_sync_q;
                        state_q <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    assign byte_vld_o = vld_q;
    assign byte_dat_o = shift_q;
    assign ferr_o     = ferr_q;

endmodule

// File: rtl/darkuart_bridge.sv
// Serial-to-bus debug bridge: 8N1 command frames in, single RD/WR bus cycles out, ACK/NAK/data back.
// Latency: bus strobe 1 cycle after last frame byte; reply starts 2-3 cycles after the bus cycle.
// Backpressure: none; host must wait for the reply, bytes received while replying are dropped.
// Ports: CLK, RES (async active-high), RXD/TXD serial, ADDR/RD/WR/BE/DATAO/DATAI bus,
//        BUSY (FSM not idle), FERR (RX framing error pulse).
// Option: define DARKUART_BRIDGE_TIMEOUT_EN to abort partial frames after a 16-bit-time gap.
module darkuart_bridge
    import darkuart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        RXD,
    output logic        TXD,
    output logic [7:0]  ADDR,
    output logic        RD,
    output logic        WR,
    output logic [3:0]  BE,
    output logic [31:0] DATAO,
    input  logic [31:0] DATAI,
    output logic        BUSY,
    output logic        FERR
);
    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       rx_ferr;

    darkuart_bridge_rx #(.DIV(DIV)) u_rx (
        .clk_i      (CLK),
        .rst_i      (RES),
        .rxd_i      (RXD),
        .byte_vld_o (rx_vld),
        .byte_dat_o (rx_dat),
        .ferr_o     (rx_ferr)
    );

    state_e        state_q;
    logic [7:0]    cmd_q;
    logic [7:0]    addr_sh_q;
    logic [3:0]    be_sh_q;
    logic [23:0]   dat_sh_q;
    logic [1:0]    idx_q;
    logic [7:0]    addr_q;
    logic [3:0]    be_q;
    logic [31:0]   datao_q;
    logic          rd_q;
    logic          wr_q;
    logic [23:0]   rdata_q;
    logic          tx_go_q;
    logic [7:0]    tx_byte_q;

    logic          txd_q;
    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bits_q;
    logic [8:0]    tx_shift_q;
    logic          tx_done;

    // Stop period has fully elapsed this cycle
    assign tx_done = tx_busy_q && (tx_cnt_q == '0) && (tx_bits_q == '0);

    // TX shifter: start bit goes out on load, then 8 data bits and the stop bit.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_shift_q <= '1;
        end else if (tx_go_q) begin
            txd_q      <= 1'b0;
            tx_shift_q <= {1'b1, tx_byte_q};
            tx_cnt_q   <= FULL_M1;
            tx_bits_q  <= 4'd9;
            tx_busy_q  <= 1'b1;
        end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end else if (tx_bits_q == '0) begin
                tx_busy_q <= 1'b0;
            end else begin
                txd_q      <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bits_q  <= tx_bits_q - 1'b1;
                tx_cnt_q   <= FULL_M1;
            end
        end
    end

`ifdef DARKUART_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_LIM = 16 * DIV;
    localparam int TOW = $clog2(TO_LIM + 1);

    logic [TOW-1:0] to_cnt_q;
    logic           in_get;
    logic           to_expired;

    assign in_get     = (state_q == ST_GET_ADDR) || (state_q == ST_GET_BE) || (state_q == ST_GET_DATA);
    assign to_expired = in_get && !rx_vld && (to_cnt_q == TOW'(TO_LIM));

    // Gap counter restarts on every received byte and outside the collect states
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            to_cnt_q <= '0;
        end else if (!in_get || rx_vld) begin
            to_cnt_q <= '0;
        end else if (!to_expired) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`endif

    // Frame FSM. Address/BE/data are collected in shadow registers so the bus
    // outputs only change when a bus cycle is actually issued.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            addr_sh_q <= '0;
            be_sh_q   <= '0;
            dat_sh_q  <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            datao_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            tx_go_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            tx_go_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_vld) begin
                        cmd_q <= rx_dat;
                        if (rx_dat == CMD_WR || rx_dat == CMD_RD) begin
                            state_q <= ST_GET_ADDR;
                        end else begin
                            tx_byte_q <= RSP_NAK;
                            tx_go_q   <= 1'b1;
                            state_q   <= ST_SEND_NAK;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (rx_ferr) begin
                        state_q <= ST_IDLE;
                    end else if (rx_vld) begin
                        if (cmd_q == CMD_WR) begin
                            addr_sh_q <= rx_dat;
                            state_q   <= ST_GET_BE;
                        end else begin
                            addr_q  <= rx_dat;
                            be_q    <= 4'hF;
                            rd_q    <= 1'b1;
                            state_q <= ST_BUS_RD;
                        end
                    end
                end
                ST_GET_BE: begin
                    if (rx_ferr) begin
                        state_q <= ST_IDLE;
                    end else if (rx_vld) begin
                        be_sh_q <= rx_dat[3:0];
                        idx_q   <= '0;
                        state_q <= ST_GET_DATA;
                    end
                end
                ST_GET_DATA: begin
                    if (rx_ferr) begin
                        state_q <= ST_IDLE;
                    end else if (rx_vld) begin
                        if (idx_q == 2'd3) begin
                            addr_q  <= addr_sh_q;
                            be_q    <= be_sh_q;
                            datao_q <= {rx_dat, dat_sh_q};
                            wr_q    <= 1'b1;
                            state_q <= ST_BUS_WR;
                        end else begin
                            // Little-endian: earlier bytes shift toward bit 0
                            dat_sh_q <= {rx_dat, dat_sh_q[23:8]};
                            idx_q    <= idx_q + 1'b1;
                        end
                    end
                end
                ST_BUS_WR: begin
                    tx_byte_q <= RSP_ACK;
                    tx_go_q   <= 1'b1;
                    state_q   <= ST_SEND_ACK;
                end
                ST_BUS_RD: begin
                    state_q <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    tx_byte_q <= DATAI[7:0];
                    rdata_q   <= DATAI[31:8];
                    idx_q     <= '0;
                    tx_go_q   <= 1'b1;
                    state_q   <= ST_SEND_DATA;
                end
                ST_SEND_ACK, ST_SEND_NAK: begin
                    if (tx_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND_DATA: begin
                    if (tx_done) begin
                        if (idx_q == 2'd3) begin
                            state_q <= ST_IDLE;
                        end else begin
                            tx_byte_q <= rdata_q[7:0];
                            rdata_q   <= {8'h00, rdata_q[23:8]};
                            idx_q     <= idx_q + 1'b1;
                            tx_go_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef DARKUART_BRIDGE_TIMEOUT_EN
            if (to_expired) begin
                state_q <= ST_IDLE;
            end
`endif
        end
    end

    assign TXD   = txd_q;
    assign ADDR  = addr_q;
    assign RD    = rd_q;
    assign WR    = wr_q;
    assign BE    = be_q;
    assign DATAO = datao_q;
    assign BUSY  = (state_q != ST_IDLE);
    assign FERR  = rx_ferr;

endmodule

// File: tb/tb_darkuart_bridge.sv
// Self-checking bench for darkuart_bridge: serial frames in, bus events and serial replies checked.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_darkuart_bridge;
    localparam int DIV = 10;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        RXD = 1'b1;
    logic [31:0] DATAI = '0;
    logic        TXD;
    logic [7:0]  ADDR;
    logic        RD;
    logic        WR;
    logic [3:0]  BE;
    logic [31:0] DATAO;
    logic        BUSY;
    logic        FERR;

    darkuart_bridge #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .CLK   (CLK),
        .RES   (RES),
        .RXD   (RXD),
        .TXD   (TXD),
        .ADDR  (ADDR),
        .RD    (RD),
        .WR    (WR),
        .BE    (BE),
        .DATAO (DATAO),
        .DATAI (DATAI),
        .BUSY  (BUSY),
        .FERR  (FERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_ev_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    wr_ev_t      wrq[$];
    logic [7:0]  rdq[$];
    logic [7:0]  txq[$];
    int          txs[$];
    logic        txb[$];
    int          strobe_err = 0;
    int          be_err     = 0;
    int          ferr_cnt   = 0;
    int          stop_err   = 0;
    logic        rd_prev    = 1'b0;
    logic        wr_prev    = 1'b0;
    logic [31:0] slave_val  = '0;
    logic        tx_prev    = 1'b1;
    logic [7:0]  mon_b;
    int          mon_start;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Bus observer: strobe events and protocol rules
    always @(negedge CLK) begin
        if (!RES) begin
            if (WR) wrq.push_back({ADDR, BE, DATAO});
            if (RD) begin
                rdq.push_back(ADDR);
                if (BE !== 4'hF) be_err++;
            end
            if (RD && WR) strobe_err++;
            if ((RD && rd_prev) || (WR && wr_prev)) strobe_err++;
            if (FERR) ferr_cnt++;
        end
        rd_prev = RD;
        wr_prev = WR;
    end

    // Slave with one-cycle read latency; garbage on DATAI at all other times
    always @(posedge CLK) begin
        #1;
        DATAI = rd_prev ? slave_val : $urandom();
    end

    // Independent 8N1 decoder on TXD
    always begin
        @(negedge CLK);
        if (!RES && tx_prev && !TXD) begin
            mon_start = cyc;
            repeat (DIV / 2) @(negedge CLK);
            if (!TXD) begin
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge CLK);
                    mon_b[k] = TXD;
                end
                repeat (DIV) @(negedge CLK);
                if (!TXD) stop_err++;
                txq.push_back(mon_b);
                txs.push_back(mon_start);
                txb.push_back(BUSY);
            end
        end
        tx_prev = TXD;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one 8N1 byte; nbits < 8 cuts the byte short (no stop bit)
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1, input int nbits = 8);
        RXD = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            RXD = b[i];
            repeat (DIV) @(negedge CLK);
        end
        if (nbits == 8) begin
            RXD = stop_bit;
            repeat (DIV) @(negedge CLK);
            RXD = 1'b1;
        end
    endtask

    task automatic wait_tx(input int n, input int budget);
        int t;
        t = 0;
        while (txq.size() < n && t < budget) begin
            @(negedge CLK);
            t++;
        end
        chk_eq("reply_count", txq.size(), n);
    endtask

    // Expect n reply bytes equal to w little-endian, sent back to back
    task automatic expect_reply(input string tag, input logic [31:0] w, input int n);
        int   st;
        int   s0;
        logic last_busy;
        s0 = 0;
        last_busy = 1'b0;
        wait_tx(n, (n * 10 + 30) * DIV);
        for (int i = 0; i < n && txq.size() > 0; i++) begin
            chk_eq(tag, txq.pop_front(), w[8*i +: 8]);
            last_busy = txb.pop_front();
            st = txs.pop_front();
            if (i > 0) chk_eq("b2b_gap", (st - s0 >= 10 * DIV) && (st - s0 <= 10 * DIV + 1), 1);
            s0 = st;
        end
        chk_eq("busy_in_stop", last_busy, 1);
        repeat (DIV) @(negedge CLK);
        chk_eq("busy_idle", BUSY, 0);
        txq.delete();
        txs.delete();
        txb.delete();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] be_byte, input logic [31:0] d);
        wr_ev_t ev;
        send_byte(8'h57);
        send_byte(a);
        send_byte(be_byte);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        expect_reply("ack", 32'h06, 1);
        chk_eq("wr_count", wrq.size(), 1);
        if (wrq.size() > 0) begin
            ev = wrq.pop_front();
            chk_eq("wr_addr", ev.addr, a);
            chk_eq("wr_be", ev.be, be_byte[3:0]);
            chk_eq("wr_data", ev.data, d);
        end
        chk_eq("wr_no_rd", rdq.size(), 0);
        wrq.delete();
        rdq.delete();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] v);
        slave_val = v;
        send_byte(8'h52);
        send_byte(a);
        expect_reply("rd_data", v, 4);
        chk_eq("rd_count", rdq.size(), 1);
        if (rdq.size() > 0) chk_eq("rd_addr", rdq.pop_front(), a);
        chk_eq("rd_no_wr", wrq.size(), 0);
        wrq.delete();
        rdq.delete();
    endtask

    task automatic do_bad(input logic [7:0] c);
        send_byte(c);
        expect_reply("nak", 32'h15, 1);
        chk_eq("bad_no_bus", wrq.size() + rdq.size(), 0);
        wrq.delete();
        rdq.delete();
    endtask

    initial begin
        int          f0;
        int          sel;
        logic [7:0]  c;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] d;
        wr_ev_t      ev;

        // Reset state
        repeat (3) @(negedge CLK);
        chk_eq("rst_txd", TXD, 1);
        chk_eq("rst_rd", RD, 0);
        chk_eq("rst_wr", WR, 0);
        chk_eq("rst_be", BE, 0);
        chk_eq("rst_addr", ADDR, 0);
        chk_eq("rst_datao", DATAO, 0);
        chk_eq("rst_busy", BUSY, 0);
        chk_eq("rst_ferr", FERR, 0);
        RES = 1'b0;
        repeat (5) @(negedge CLK);

        // Directed frames
        do_write(8'h10, 8'h0F, 32'h12345678);
        do_read(8'h20, 32'hDEADBEEF);
        do_bad(8'h41);

        // Framing error inside a write frame
        f0 = ferr_cnt;
        send_byte(8'h57);
        send_byte(8'h33);
        send_byte(8'h0F, 1'b0);
        repeat (30 * DIV) @(negedge CLK);
        chk_eq("ferr_pulses", ferr_cnt - f0, 1);
        chk_eq("ferr_no_wr", wrq.size(), 0);
        chk_eq("ferr_no_reply", txq.size(), 0);
        chk_eq("ferr_idle", BUSY, 0);
        do_write(8'h44, 8'h03, 32'hA5A55A5A);

        // Reset in the middle of the third data byte
        send_byte(8'h57);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33, 1'b1, 4);
        #2;
        RES = 1'b1;
        #1;
        chk_eq("mid_rst_txd", TXD, 1);
        chk_eq("mid_rst_rd", RD, 0);
        chk_eq("mid_rst_wr", WR, 0);
        chk_eq("mid_rst_be", BE, 0);
        chk_eq("mid_rst_addr", ADDR, 0);
        chk_eq("mid_rst_datao", DATAO, 0);
        chk_eq("mid_rst_busy", BUSY, 0);
        chk_eq("mid_rst_ferr", FERR, 0);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RES = 1'b0;
        repeat (2 * DIV) @(negedge CLK);
        chk_eq("mid_rst_no_wr", wrq.size(), 0);
        wrq.delete();
        do_write(8'h7E, 8'hF9, 32'hCAFEF00D);

        // Randomized mix of frames
        for (int n = 0; n < 8; n++) begin
            sel = int'($urandom_range(0, 2));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            d = $urandom();
            if (sel == 0) begin
                do_write(a, b, d);
            end else if (sel == 1) begin
                do_read(a, d);
            end else begin
                c = 8'($urandom_range(0, 255));
                while (c == 8'h57 || c == 8'h52) c = 8'($urandom_range(0, 255));
                do_bad(c);
            end
        end

        // Long inter-byte gap after the address byte
        send_byte(8'h57);
        send_byte(8'h10);
        repeat (200) @(negedge CLK);
`ifdef DARKUART_BRIDGE_TIMEOUT_EN
        chk_eq("to_idle", BUSY, 0);
        chk_eq("to_no_wr", wrq.size(), 0);
        chk_eq("to_no_reply", txq.size(), 0);
        do_read(8'h21, 32'h0BADF00D);
`else
        chk_eq("gap_busy", BUSY, 1);
        send_byte(8'h0F);
        for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i));
        expect_reply("gap_ack", 32'h06, 1);
        chk_eq("gap_wr_count", wrq.size(), 1);
        if (wrq.size() > 0) begin
            ev = wrq.pop_front();
            chk_eq("gap_wr_addr", ev.addr, 8'h10);
            chk_eq("gap_wr_data", ev.data, 32'h93929190);
        end
        wrq.delete();
`endif

        chk_eq("strobe_rules", strobe_err, 0);
        chk_eq("rd_be_all", be_err, 0);
        chk_eq("tx_stop_bits", stop_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
